// File: rtl/irq_priority_controller_pkg.sv
// Shared constants, IACK state encoding and the priority encoder helper
// for the 68000 interrupt controller.
package irq_ctrl_pkg;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_MODE    = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [2:0] FC_IACK = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ACK,
        SPUR
    } iack_state_e;

    // Bit i of act is level i+1; result is the highest active level, 0 if none.
    function automatic logic [2:0] highest_level(input logic [6:0] act);
        highest_level = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (act[i]) begin
                highest_level = 3'(i + 1);
            end
        end
    endfunction

endpackage

// File: rtl/irq_priority_controller_if.sv
// CPU bus strobes, register access port and interrupt outputs of the controller.
interface irq_priority_controller_if;
    logic       AS_IN;
    logic       UDS_IN;
    logic       LDS_IN;
    logic [2:0] MPU_STATUS_CODE_IN;
    logic [2:0] ADDR_IN;
    logic       REG_CS_IN;
    logic       REG_WR_IN;
    logic [1:0] REG_ADDR_IN;
    logic [7:0] REG_WDATA_IN;
    logic [7:0] REG_RDATA;
    logic [2:0] INT_LEVEL;
    logic       INT_AUTOVEC_ACK;
    logic       INT_SPURIOUS;
    logic       IACK_STROBE;
    logic [2:0] IACK_LEVEL;

    modport master (
        output AS_IN, UDS_IN, LDS_IN, MPU_STATUS_CODE_IN, ADDR_IN,
        output REG_CS_IN, REG_WR_IN, REG_ADDR_IN, REG_WDATA_IN,
        input  REG_RDATA, INT_LEVEL, INT_AUTOVEC_ACK, INT_SPURIOUS,
        input  IACK_STROBE, IACK_LEVEL
    );

    modport slave (
        input  AS_IN, UDS_IN, LDS_IN, MPU_STATUS_CODE_IN, ADDR_IN,
        input  REG_CS_IN, REG_WR_IN, REG_ADDR_IN, REG_WDATA_IN,
        output REG_RDATA, INT_LEVEL, INT_AUTOVEC_ACK, INT_SPURIOUS,
        output IACK_STROBE, IACK_LEVEL
    );
endinterface

// File: rtl/irq_priority_controller_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request plus rising-edge detect
// on the synchronised value.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic run_ni,
    input  logic irq_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk_i) begin
        if (!run_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History follows the synced level every cycle regardless of MODE, so a
    // source switched to edge mode never sees a stale 0->1 transition.
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_priority_controller.sv
// Seven-source prioritised interrupt controller: pending/enable registers,
// registered IPL encoder and the IACK (autovector / spurious) sequencer.
module irq_priority_controller #(
    parameter int NUM_SRC     = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic               CPUCLK_IN,
    input  logic               RUN_IN,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    irq_priority_controller_if.slave bus
);
    import irq_ctrl_pkg::*;

    logic [NUM_SRC-1:0] level_w;
    logic [NUM_SRC-1:0] rise_w;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] active_w;
    logic [NUM_SRC-1:0] w1c_w;
    logic [NUM_SRC-1:0] clear_w;
    logic [6:0]         active7_w;
    logic [7:0]         act8_w;
    logic [7:0]         clr8_w;
    logic [7:0]         rdata_d;
    logic [7:0]         rdata_q;
    logic [2:0]         int_level_q;
    logic [2:0]         last_ack_q;
    logic [2:0]         iack_level_q;
    logic               avec_q;
    logic               spur_q;
    logic               strobe_q;
    logic               wr_en_w;
    logic               rd_en_w;
    logic               iack_cycle_w;
    logic               ack_hit_w;
    logic               unused_w;
    iack_state_e        state_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk_i  (CPUCLK_IN),
                .run_ni (RUN_IN),
                .irq_i  (IRQ_IN[gi]),
                .level_o(level_w[gi]),
                .rise_o (rise_w[gi])
            );

            // A new edge is ORed in after the clear, so set beats clear.
            assign pending_d[gi] = mode_q[gi]
                ? (rise_w[gi] | (pending_q[gi] & ~clear_w[gi]))
                : level_w[gi];
        end
    endgenerate

    assign wr_en_w      = bus.REG_CS_IN & bus.REG_WR_IN;
    assign rd_en_w      = bus.REG_CS_IN & ~bus.REG_WR_IN;
    assign active_w     = pending_q & enable_q;
    assign active7_w    = 7'(active_w);
    assign act8_w       = {active7_w, 1'b0};
    assign iack_cycle_w = bus.AS_IN & bus.UDS_IN & bus.LDS_IN
                        & (bus.MPU_STATUS_CODE_IN == FC_IACK);
    assign ack_hit_w    = (state_q == CHECK) && act8_w[bus.ADDR_IN];
    assign clr8_w       = ack_hit_w ? (8'd1 << bus.ADDR_IN) : 8'd0;
    assign w1c_w        = (wr_en_w && bus.REG_ADDR_IN == REG_PENDING)
                        ? bus.REG_WDATA_IN[NUM_SRC-1:0] : '0;
    assign clear_w      = w1c_w | clr8_w[NUM_SRC:1];
    assign unused_w     = ^{bus.REG_WDATA_IN, clr8_w};

    always_comb begin
        rdata_d = 8'd0;
        case (bus.REG_ADDR_IN)
            REG_ENABLE:  rdata_d = 8'(enable_q);
            REG_MODE:    rdata_d = 8'(mode_q);
            REG_PENDING: rdata_d = 8'(pending_q);
            default:     rdata_d = {1'b0, last_ack_q, 1'b0, int_level_q};
        endcase
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (!RUN_IN) begin
            enable_q    <= '0;
            mode_q      <= '0;
            pending_q   <= '0;
            int_level_q <= 3'd0;
            rdata_q     <= 8'd0;
        end else begin
            pending_q   <= pending_d;
            int_level_q <= highest_level(active7_w);
            if (wr_en_w && bus.REG_ADDR_IN == REG_ENABLE) begin
                enable_q <= bus.REG_WDATA_IN[NUM_SRC-1:0];
            end
            if (wr_en_w && bus.REG_ADDR_IN == REG_MODE) begin
                mode_q <= bus.REG_WDATA_IN[NUM_SRC-1:0];
            end
            if (rd_en_w) begin
                rdata_q <= rdata_d;
            end
        end
    end

    always_ff @(posedge CPUCLK_IN) begin
        if (!RUN_IN) begin
            state_q      <= IDLE;
            avec_q       <= 1'b0;
            spur_q       <= 1'b0;
            strobe_q     <= 1'b0;
            iack_level_q <= 3'd0;
            last_ack_q   <= 3'd0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iack_cycle_w) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (ack_hit_w) begin
                        state_q      <= ACK;
                        strobe_q     <= 1'b1;
                        avec_q       <= 1'b1;
                        iack_level_q <= bus.ADDR_IN;
                        last_ack_q   <= bus.ADDR_IN;
                    end else begin
                        state_q <= SPUR;
                        spur_q  <= 1'b1;
                    end
                end
                default: begin
                    if (!bus.AS_IN) begin
                        state_q <= IDLE;
                        avec_q  <= 1'b0;
                        spur_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.REG_RDATA       = rdata_q;
    assign bus.INT_LEVEL       = int_level_q;
    assign bus.INT_AUTOVEC_ACK = avec_q;
    assign bus.INT_SPURIOUS    = spur_q;
    assign bus.IACK_STROBE     = strobe_q;
    assign bus.IACK_LEVEL      = iack_level_q;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Self-checking bench for irq_priority_controller: register table, scoreboarded
// reads and hand-written IACK / latency / reset sequences.
module tb_irq_priority_controller;

    localparam int NUM_SRC     = 7;
    localparam int SYNC_STAGES = 2;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } reg_vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    logic               clk;
    logic               run;
    logic [NUM_SRC-1:0] irq;
    int                 checks;
    int                 errors;
    reg_vec_t           vecs [6];
    sb_t                sb_q [$];

    irq_priority_controller_if bus_if ();

    irq_priority_controller #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CPUCLK_IN(clk),
        .RUN_IN   (run),
        .IRQ_IN   (irq),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.AS_IN              = 1'b0;
        bus_if.UDS_IN             = 1'b0;
        bus_if.LDS_IN             = 1'b0;
        bus_if.MPU_STATUS_CODE_IN = 3'd0;
        bus_if.ADDR_IN            = 3'd0;
        bus_if.REG_CS_IN          = 1'b0;
        bus_if.REG_WR_IN          = 1'b0;
        bus_if.REG_ADDR_IN        = 2'd0;
        bus_if.REG_WDATA_IN       = 8'd0;
    endtask

    task automatic do_reset();
        run = 1'b0;
        irq = '0;
        bus_idle();
        repeat (2) tick();
        run = 1'b1;
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [7:0] data);
        bus_if.REG_CS_IN    = 1'b1;
        bus_if.REG_WR_IN    = 1'b1;
        bus_if.REG_ADDR_IN  = addr;
        bus_if.REG_WDATA_IN = data;
        tick();
        bus_if.REG_CS_IN    = 1'b0;
        bus_if.REG_WR_IN    = 1'b0;
        $display("write reg%0d = %02h", addr, data);
    endtask

    task automatic reg_read(input logic [1:0] addr, input logic [7:0] exp, input string name);
        sb_t item;
        sb_q.push_back('{name: name, exp: exp});
        bus_if.REG_CS_IN   = 1'b1;
        bus_if.REG_WR_IN   = 1'b0;
        bus_if.REG_ADDR_IN = addr;
        tick();
        bus_if.REG_CS_IN   = 1'b0;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=empty-scoreboard required=entry", name);
        end else begin
            item = sb_q.pop_front();
            check(item.name, 32'(bus_if.REG_RDATA), 32'(item.exp));
            $display("read reg%0d = %02h (want %02h)", addr, bus_if.REG_RDATA, item.exp);
        end
    endtask

    // One-cycle request pulse, then follow INT_LEVEL through its latency window.
    task automatic pulse_and_wait(input logic [NUM_SRC-1:0] mask, input logic [2:0] exp_lvl,
                                  input string name);
        irq = mask;
        tick();
        irq = '0;
        repeat (SYNC_STAGES) tick();
        check({name, "_early"}, 32'(bus_if.INT_LEVEL), 32'd0);
        tick();
        check(name, 32'(bus_if.INT_LEVEL), 32'(exp_lvl));
        $display("pulse irq=%02h int_level=%0d", mask, bus_if.INT_LEVEL);
    endtask

    task automatic do_iack(input logic [2:0] lvl, input logic exp_ack, input string name);
        int strobes;
        strobes = 0;
        bus_if.AS_IN              = 1'b1;
        bus_if.UDS_IN             = 1'b1;
        bus_if.LDS_IN             = 1'b1;
        bus_if.MPU_STATUS_CODE_IN = 3'b111;
        bus_if.ADDR_IN            = lvl;
        tick();
        strobes += int'(bus_if.IACK_STROBE);
        tick();
        strobes += int'(bus_if.IACK_STROBE);
        check({name, "_avec"}, 32'(bus_if.INT_AUTOVEC_ACK), 32'(exp_ack));
        check({name, "_spur"}, 32'(bus_if.INT_SPURIOUS), 32'(!exp_ack));
        if (exp_ack) begin
            check({name, "_iack_level"}, 32'(bus_if.IACK_LEVEL), 32'(lvl));
        end
        repeat (2) begin
            tick();
            strobes += int'(bus_if.IACK_STROBE);
        end
        check({name, "_held"}, 32'({bus_if.INT_AUTOVEC_ACK, bus_if.INT_SPURIOUS}),
              32'({exp_ack, !exp_ack}));
        bus_idle();
        tick();
        strobes += int'(bus_if.IACK_STROBE);
        check({name, "_drop"}, 32'({bus_if.INT_AUTOVEC_ACK, bus_if.INT_SPURIOUS}), 32'd0);
        check({name, "_strobes"}, 32'(strobes), 32'(exp_ack));
        $display("iack level=%0d ack=%0b strobes=%0d", lvl, exp_ack, strobes);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{addr: 2'd0, wdata: 8'hFF, exp: 8'h7F};
        vecs[1] = '{addr: 2'd1, wdata: 8'hAA, exp: 8'h2A};
        vecs[2] = '{addr: 2'd0, wdata: 8'h80, exp: 8'h00};
        vecs[3] = '{addr: 2'd1, wdata: 8'h7F, exp: 8'h7F};
        vecs[4] = '{addr: 2'd0, wdata: 8'h5A, exp: 8'h5A};
        vecs[5] = '{addr: 2'd1, wdata: 8'h00, exp: 8'h00};

        // Reset state
        do_reset();
        tick();
        check("rst_int_level", 32'(bus_if.INT_LEVEL), 32'd0);
        check("rst_avec", 32'(bus_if.INT_AUTOVEC_ACK), 32'd0);
        check("rst_spur", 32'(bus_if.INT_SPURIOUS), 32'd0);
        check("rst_strobe", 32'(bus_if.IACK_STROBE), 32'd0);
        check("rst_rdata", 32'(bus_if.REG_RDATA), 32'd0);
        reg_read(2'd3, 8'h00, "rst_status");

        // Register table
        for (int i = 0; i < 6; i++) begin
            reg_write(vecs[i].addr, vecs[i].wdata);
            reg_read(vecs[i].addr, vecs[i].exp, $sformatf("regvec%0d", i));
        end
        reg_write(2'd0, 8'h00);

        // 1: single edge source, latency, autovector ack
        do_reset();
        reg_write(2'd0, 8'h02);
        reg_write(2'd1, 8'h02);
        pulse_and_wait(7'h02, 3'd2, "t1_level");
        reg_read(2'd2, 8'h02, "t1_pending");
        do_iack(3'd2, 1'b1, "t1_iack");
        reg_read(2'd2, 8'h00, "t1_pending_clr");
        check("t1_level_after", 32'(bus_if.INT_LEVEL), 32'd0);

        // 2: two edge sources, priority ordering
        do_reset();
        reg_write(2'd0, 8'h05);
        reg_write(2'd1, 8'h05);
        pulse_and_wait(7'h05, 3'd3, "t2_level");
        do_iack(3'd3, 1'b1, "t2_iack3");
        check("t2_level1", 32'(bus_if.INT_LEVEL), 32'd1);
        do_iack(3'd1, 1'b1, "t2_iack1");
        check("t2_level0", 32'(bus_if.INT_LEVEL), 32'd0);
        reg_read(2'd3, 8'h10, "t2_status");

        // 3: level source is not cleared by IACK
        do_reset();
        reg_write(2'd0, 8'h10);
        irq = 7'h10;
        repeat (SYNC_STAGES + 2) tick();
        check("t3_level", 32'(bus_if.INT_LEVEL), 32'd5);
        do_iack(3'd5, 1'b1, "t3_iack");
        reg_read(2'd2, 8'h10, "t3_pending");
        check("t3_level_held", 32'(bus_if.INT_LEVEL), 32'd5);
        irq = '0;
        repeat (SYNC_STAGES + 2) tick();
        check("t3_level_gone", 32'(bus_if.INT_LEVEL), 32'd0);

        // 4: spurious acknowledge
        do_iack(3'd4, 1'b0, "t4_spur");
        reg_read(2'd3, 8'h50, "t4_status");

        // 5: W1C, then W1C colliding with a new edge, then masking
        do_reset();
        reg_write(2'd0, 8'h01);
        reg_write(2'd1, 8'h01);
        pulse_and_wait(7'h01, 3'd1, "t5_level");
        reg_write(2'd2, 8'h01);
        reg_read(2'd2, 8'h00, "t5_w1c");
        irq = 7'h01;
        tick();
        irq = '0;
        tick();
        reg_write(2'd2, 8'h01);
        reg_read(2'd2, 8'h01, "t5_set_wins");
        reg_write(2'd0, 8'h00);
        tick();
        check("t5_masked_level", 32'(bus_if.INT_LEVEL), 32'd0);
        reg_read(2'd2, 8'h01, "t5_pending_kept");

        // 6: reset during an acknowledge
        do_reset();
        reg_write(2'd0, 8'h02);
        reg_write(2'd1, 8'h02);
        pulse_and_wait(7'h02, 3'd2, "t6_level");
        bus_if.AS_IN              = 1'b1;
        bus_if.UDS_IN             = 1'b1;
        bus_if.LDS_IN             = 1'b1;
        bus_if.MPU_STATUS_CODE_IN = 3'b111;
        bus_if.ADDR_IN            = 3'd2;
        repeat (2) tick();
        check("t6_avec_before", 32'(bus_if.INT_AUTOVEC_ACK), 32'd1);
        run = 1'b0;
        tick();
        check("t6_avec_reset", 32'(bus_if.INT_AUTOVEC_ACK), 32'd0);
        check("t6_level_reset", 32'(bus_if.INT_LEVEL), 32'd0);
        run = 1'b1;
        bus_idle();
        reg_read(2'd0, 8'h00, "t6_enable");
        reg_read(2'd1, 8'h00, "t6_mode");
        reg_read(2'd2, 8'h00, "t6_pending");
        reg_read(2'd3, 8'h00, "t6_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
